turbo_tail_deformat: RTL

// Receive-side counterpart of the turbo-encoder trellis termination. Collects the 12 tail LLRs that

---
 rtl/turbo_tail_deformat.sv | 126 ++++++++++++
 1 files changed

// File: rtl/turbo_tail_deformat.sv
// Collects the 12 turbo trellis-termination LLRs, splits them into per-constituent
// systematic/parity tail vectors, and recovers and checks each encoder's pre-termination state.
module turbo_tail_deformat #(
  parameter int unsigned W = 6
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W-1:0]    in_llr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3*W-1:0]  tail_n_sys,
  output logic [3*W-1:0]  tail_n_par,
  output logic [3*W-1:0]  tail_m_sys,
  output logic [3*W-1:0]  tail_m_par,
  output logic [2:0]      state_n,
  output logic [2:0]      state_m,
  output logic [1:0]      chk_err,
  output logic            busy
);

  localparam int unsigned N_BEATS = 12;
  localparam int unsigned CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    CHECK   = 2'd2,
    OUT     = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic               beat_store;
  logic [W-1:0]       slot [N_BEATS];
  logic [2:0]         xn, zn, xm, zm;

  function automatic logic hb(input logic [W-1:0] v);
    return v[W-1];
  endfunction

  // x = {x2,x1,x0}; returns {s1,s2,s3}
  function automatic logic [2:0] term_state(input logic [2:0] x);
    return {x[2], x[1] ^ x[2], x[0] ^ x[1] ^ x[2]};
  endfunction

  function automatic logic term_err(input logic [2:0] x, input logic [2:0] z);
    return (z[0] ^ x[0] ^ x[1]) | (z[1] ^ x[1] ^ x[2]) | (z[2] ^ x[2]);
  endfunction

  // Serial order interleaves d0/d1/d2 tails of both encoders; regroup as {k2,k1,k0}
  assign xn = {hb(slot[5]), hb(slot[8]),  hb(slot[0])};
  assign zn = {hb(slot[9]), hb(slot[1]),  hb(slot[4])};
  assign xm = {hb(slot[7]), hb(slot[10]), hb(slot[2])};
  assign zm = {hb(slot[11]), hb(slot[3]), hb(slot[6])};

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    beat_store = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = COLLECT;
          cnt_nxt   = '0;
        end
      end
      COLLECT: begin
        // restart wins over a same-cycle beat
        if (start) begin
          cnt_nxt = '0;
        end else if (in_valid && in_ready) begin
          beat_store = 1'b1;
          if (cnt == CNT_W'(N_BEATS - 1)) begin
            state_nxt = CHECK;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      CHECK:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      tail_n_sys <= '0;
      tail_n_par <= '0;
      tail_m_sys <= '0;
      tail_m_par <= '0;
      state_n    <= '0;
      state_m    <= '0;
      chk_err    <= '0;
      for (int unsigned i = 0; i < N_BEATS; i++) slot[i] <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      in_ready  <= (state_nxt == COLLECT);
      out_valid <= (state_nxt == OUT);
      busy      <= (state_nxt != IDLE);
      for (int unsigned i = 0; i < N_BEATS; i++) begin
        if (beat_store && cnt == CNT_W'(i)) slot[i] <= in_llr;
      end
      if (state == CHECK) begin
        tail_n_sys <= {slot[5], slot[8],  slot[0]};
        tail_n_par <= {slot[9], slot[1],  slot[4]};
        tail_m_sys <= {slot[7], slot[10], slot[2]};
        tail_m_par <= {slot[11], slot[3], slot[6]};
        state_n    <= term_state(xn);
        state_m    <= term_state(xm);
        chk_err    <= {term_err(xm, zm), term_err(xn, zn)};
      end
    end
  end

endmodule
